// File: rtl/memory_access.sv
// memory_access: memory stage of a simple in-order pipeline.
//
// Captures the execute-stage instruction fields on every unstalled edge,
// issues at most one word load/store to a handshaked data memory and retires
// each instruction with a one-cycle valid_o strobe together with the
// writeback controls. Non-memory instructions retire one cycle after capture;
// memory instructions stall the upstream stage until ack or timeout.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   valid_i .. storeData_i  execute-stage instruction fields
//   dmem*_o / dmem*_i     data-memory request/ack handshake
//   stall_o               upstream must hold its outputs
//   pcSrc_o, pcBranch_o, pcPlus4_o  branch redirect and fall-through PC
//   valid_o, regWrite_o, rd_o, wd3_o  retire strobe and writeback
//   err_o                 sticky access error (misaligned, R+W, timeout)
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        wdSrc_i,
  input  logic        regWrite_i,
  input  logic        branch_i,
  input  logic        condZero_i,
  input  logic        aluZero_i,
  input  logic [31:0] aluResult_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] immU_i,
  input  logic [31:0] pcBranch_i,
  input  logic [31:0] pcPlus4_i,
  input  logic        memRead_i,
  input  logic        memWrite_i,
  input  logic [31:0] storeData_i,
  output logic        dmemReq_o,
  output logic        dmemWe_o,
  output logic [31:0] dmemAddr_o,
  output logic [31:0] dmemWdata_o,
  input  logic        dmemAck_i,
  input  logic [31:0] dmemRdata_i,
  output logic        stall_o,
  output logic        pcSrc_o,
  output logic [31:0] pcBranch_o,
  output logic [31:0] pcPlus4_o,
  output logic        valid_o,
  output logic        regWrite_o,
  output logic [4:0]  rd_o,
  output logic [31:0] wd3_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  // Last WAIT cycle index before giving up (15 cycles: counts 0..14).
  localparam logic [3:0] TIMEOUT_LAST = 4'd14;

  // ---------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------
  logic        valid_q, wdSrc_q, regWrite_q, branch_q, condZero_q, aluZero_q;
  logic        memRead_q, memWrite_q;
  logic [31:0] aluResult_q, immU_q, pcBranch_q, pcPlus4_q, storeData_q;
  logic [4:0]  rd_q;

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_q;      // dmemReq_o
  logic        stall_q;    // high exactly while in WAIT
  logic        vld_q;      // retire strobe
  logic        ierr_q;     // error attached to the retiring instruction
  logic        err_q;      // sticky error
  logic [31:0] rdata_q;    // latched load data

  // Decode of the incoming instruction, used on the capture edge so that a
  // memory op enters WAIT in the very cycle after capture.
  logic misal, any_mem, go_mem, bad_mem;

  assign misal   = aluResult_i[1:0] != 2'b00;
  assign any_mem = memRead_i | memWrite_i;
  assign go_mem  = valid_i & (memRead_i ^ memWrite_i) & ~misal;
  assign bad_mem = valid_i & any_mem & ((memRead_i & memWrite_i) | misal);

  // Stage capture: stall_q is only set in WAIT, so fields are held for the
  // whole request and through the RESP cycle, then refreshed on RESP exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      wdSrc_q     <= 1'b0;
      regWrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      condZero_q  <= 1'b0;
      aluZero_q   <= 1'b0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      aluResult_q <= '0;
      immU_q      <= '0;
      pcBranch_q  <= '0;
      pcPlus4_q   <= '0;
      storeData_q <= '0;
      rd_q        <= '0;
    end else if (!stall_q) begin
      valid_q     <= valid_i;
      wdSrc_q     <= wdSrc_i;
      regWrite_q  <= regWrite_i;
      branch_q    <= branch_i;
      condZero_q  <= condZero_i;
      aluZero_q   <= aluZero_i;
      memRead_q   <= memRead_i;
      memWrite_q  <= memWrite_i;
      aluResult_q <= aluResult_i;
      immU_q      <= immU_i;
      pcBranch_q  <= pcBranch_i;
      pcPlus4_q   <= pcPlus4_i;
      storeData_q <= storeData_i;
      rd_q        <= rd_i;
    end
  end

  // FSM. IDLE and RESP behave identically on their exit edge: both capture
  // the next instruction. RESP only marks the retire cycle of a memory op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      stall_q <= 1'b0;
      vld_q   <= 1'b0;
      ierr_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (dmemAck_i) begin
            rdata_q <= dmemRdata_i;
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            vld_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= RESP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            // No ack in time: abandon the access and retire without writeback.
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            vld_q   <= 1'b1;
            ierr_q  <= 1'b1;
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          // Clear so an errored load never writes back stale data.
          rdata_q <= '0;
          cnt_q   <= '0;
          if (go_mem) begin
            req_q   <= 1'b1;
            stall_q <= 1'b1;
            vld_q   <= 1'b0;
            ierr_q  <= 1'b0;
            state_q <= WAIT;
          end else begin
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            vld_q   <= valid_i;
            ierr_q  <= bad_mem;
            err_q   <= err_q | bad_mem;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all derived from registers only.
  // ---------------------------------------------------------------------
  assign stall_o     = stall_q;
  assign dmemReq_o   = req_q;
  assign dmemWe_o    = req_q & memWrite_q;
  assign dmemAddr_o  = req_q ? aluResult_q : '0;
  assign dmemWdata_o = req_q ? storeData_q : '0;

  assign valid_o     = vld_q;
  assign regWrite_o  = vld_q & valid_q & regWrite_q & (rd_q != 5'd0) & ~ierr_q;
  assign pcSrc_o     = vld_q & valid_q & branch_q & (aluZero_q == condZero_q);
  assign pcBranch_o  = pcBranch_q;
  assign pcPlus4_o   = pcPlus4_q;
  assign rd_o        = rd_q;
  assign wd3_o       = memRead_q ? rdata_q : (wdSrc_q ? immU_q : aluResult_q);
  assign err_o       = err_q;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk, rst_n;
  logic        valid_i, wdSrc_i, regWrite_i, branch_i, condZero_i, aluZero_i;
  logic [31:0] aluResult_i, immU_i, pcBranch_i, pcPlus4_i, storeData_i;
  logic [4:0]  rd_i;
  logic        memRead_i, memWrite_i;
  logic        dmemReq_o, dmemWe_o, dmemAck_i;
  logic [31:0] dmemAddr_o, dmemWdata_o, dmemRdata_i;
  logic        stall_o, pcSrc_o, valid_o, regWrite_o, err_o;
  logic [31:0] pcBranch_o, pcPlus4_o, wd3_o;
  logic [4:0]  rd_o;

  memory_access dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .wdSrc_i(wdSrc_i), .regWrite_i(regWrite_i),
    .branch_i(branch_i), .condZero_i(condZero_i), .aluZero_i(aluZero_i),
    .aluResult_i(aluResult_i), .rd_i(rd_i), .immU_i(immU_i),
    .pcBranch_i(pcBranch_i), .pcPlus4_i(pcPlus4_i),
    .memRead_i(memRead_i), .memWrite_i(memWrite_i), .storeData_i(storeData_i),
    .dmemReq_o(dmemReq_o), .dmemWe_o(dmemWe_o), .dmemAddr_o(dmemAddr_o),
    .dmemWdata_o(dmemWdata_o), .dmemAck_i(dmemAck_i), .dmemRdata_i(dmemRdata_i),
    .stall_o(stall_o), .pcSrc_o(pcSrc_o), .pcBranch_o(pcBranch_o),
    .pcPlus4_o(pcPlus4_o), .valid_o(valid_o), .regWrite_o(regWrite_o),
    .rd_o(rd_o), .wd3_o(wd3_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd3;
    logic        pcsrc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [4:0] rd, input logic [31:0] wd3,
                      input logic pcsrc);
    exp_t e;
    e.rw = rw; e.rd = rd; e.wd3 = wd3; e.pcsrc = pcsrc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic v, input logic mr, input logic mw, input logic ws,
                       input logic rw, input logic br, input logic cz, input logic az,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [31:0] pcb,
                       input logic [31:0] pc4, input logic [31:0] sd);
    valid_i = v; memRead_i = mr; memWrite_i = mw; wdSrc_i = ws; regWrite_i = rw;
    branch_i = br; condZero_i = cz; aluZero_i = az; aluResult_i = alu; rd_i = rd;
    immU_i = imm; pcBranch_i = pcb; pcPlus4_i = pc4; storeData_i = sd;
  endtask

  // Retire monitor: every valid_o strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_retire", 32'(valid_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_regWrite", 32'(regWrite_o), 32'(e.rw));
        chk("sb_rd", 32'(rd_o), 32'(e.rd));
        chk("sb_wd3", wd3_o, e.wd3);
        chk("sb_pcSrc", 32'(pcSrc_o), 32'(e.pcsrc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqcyc;
    rst_n = 1'b0; dmemAck_i = 1'b0; dmemRdata_i = '0;
    issue(0,0,0,0,0,0,0,0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dmemReq_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_wd3", wd3_o, 32'd0);
    chk("rst_pcBranch", pcBranch_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU op, latency 1
    issue(1,0,0,0,1,0,0,0, 32'h10, 5'd5, 32'h0, 32'h0, 32'h104, 32'h0);
    push(1, 5, 32'h10, 0);
    @(negedge clk); valid_i = 1'b0;
    chk("alu_valid", 32'(valid_o), 32'd1);
    chk("alu_stall", 32'(stall_o), 32'd0);
    chk("alu_pcPlus4", pcPlus4_o, 32'h104);
    @(negedge clk);
    chk("alu_valid_once", 32'(valid_o), 32'd0);

    // immU writeback to x0: no register write
    issue(1,0,0,1,1,0,0,0, 32'h55, 5'd0, 32'hABCD0000, 32'h0, 32'h0, 32'h0);
    push(0, 0, 32'hABCD0000, 0);
    @(negedge clk); valid_i = 1'b0;
    chk("immU_valid", 32'(valid_o), 32'd1);
    @(negedge clk);

    // Taken branch
    issue(1,0,0,0,0,1,1,1, 32'h0, 5'd0, 32'h0, 32'h40, 32'h0, 32'h0);
    push(0, 0, 32'h0, 1);
    @(negedge clk); valid_i = 1'b0;
    chk("br_pcSrc", 32'(pcSrc_o), 32'd1);
    chk("br_pcBranch", pcBranch_o, 32'h40);
    @(negedge clk);
    chk("br_pcSrc_once", 32'(pcSrc_o), 32'd0);

    // Not-taken branch that writes back
    issue(1,0,0,0,1,1,1,0, 32'h7, 5'd2, 32'h0, 32'h80, 32'h0, 32'h0);
    push(1, 2, 32'h7, 0);
    @(negedge clk); valid_i = 1'b0;
    @(negedge clk);

    // Bubble carrying memRead/branch/regWrite must do nothing
    issue(0,1,0,0,1,1,1,1, 32'h100, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("bub_valid", 32'(valid_o), 32'd0);
    chk("bub_regWrite", 32'(regWrite_o), 32'd0);
    chk("bub_pcSrc", 32'(pcSrc_o), 32'd0);
    chk("bub_req", 32'(dmemReq_o), 32'd0);
    chk("bub_stall", 32'(stall_o), 32'd0);

    // Load at 0x100, ack in the third WAIT cycle
    issue(1,1,0,0,1,0,0,0, 32'h100, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0);
    push(1, 7, 32'hDEADBEEF, 0);
    @(negedge clk); valid_i = 1'b0;
    chk("ld_req", 32'(dmemReq_o), 32'd1);
    chk("ld_we", 32'(dmemWe_o), 32'd0);
    chk("ld_addr", dmemAddr_o, 32'h100);
    chk("ld_stall1", 32'(stall_o), 32'd1);
    @(negedge clk);
    chk("ld_stall2", 32'(stall_o), 32'd1);
    @(negedge clk);
    chk("ld_stall3", 32'(stall_o), 32'd1);
    chk("ld_addr_stable", dmemAddr_o, 32'h100);
    dmemAck_i = 1'b1; dmemRdata_i = 32'hDEADBEEF;
    @(negedge clk); dmemAck_i = 1'b0; dmemRdata_i = '0;
    chk("ld_resp_stall", 32'(stall_o), 32'd0);
    chk("ld_resp_req", 32'(dmemReq_o), 32'd0);
    chk("ld_resp_valid", 32'(valid_o), 32'd1);
    @(negedge clk);
    chk("ld_valid_once", 32'(valid_o), 32'd0);

    // Aligned store, immediate ack
    issue(1,0,1,0,0,0,0,0, 32'h200, 5'd0, 32'h0, 32'h0, 32'h0, 32'h12345678);
    push(0, 0, 32'h200, 0);
    @(negedge clk); valid_i = 1'b0;
    chk("st_we", 32'(dmemWe_o), 32'd1);
    chk("st_wdata", dmemWdata_o, 32'h12345678);
    dmemAck_i = 1'b1;
    @(negedge clk); dmemAck_i = 1'b0;
    chk("st_valid", 32'(valid_o), 32'd1);
    @(negedge clk);
    chk("st_err_clear", 32'(err_o), 32'd0);

    // Misaligned store at 0x102
    issue(1,0,1,0,1,0,0,0, 32'h102, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0);
    push(0, 3, 32'h102, 0);
    @(negedge clk); valid_i = 1'b0;
    chk("mis_req", 32'(dmemReq_o), 32'd0);
    chk("mis_err", 32'(err_o), 32'd1);
    chk("mis_valid", 32'(valid_o), 32'd1);
    chk("mis_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    chk("mis_valid_once", 32'(valid_o), 32'd0);

    // Read and write together: error, no request
    issue(1,1,1,0,1,0,0,0, 32'h20, 5'd6, 32'h0, 32'h0, 32'h0, 32'h0);
    push(0, 6, 32'h0, 0);
    @(negedge clk); valid_i = 1'b0;
    chk("rw_req", 32'(dmemReq_o), 32'd0);
    @(negedge clk);

    // Error stays sticky; later clean instruction still writes back
    issue(1,0,0,0,1,0,0,0, 32'h33, 5'd8, 32'h0, 32'h0, 32'h0, 32'h0);
    push(1, 8, 32'h33, 0);
    @(negedge clk); valid_i = 1'b0;
    chk("sticky_err", 32'(err_o), 32'd1);
    @(negedge clk);

    // Reset clears the sticky error
    rst_n = 1'b0; #1;
    chk("rst2_err", 32'(err_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Load never acked: 15 request cycles then error retire
    issue(1,1,0,0,1,0,0,0, 32'h300, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0);
    push(0, 4, 32'h0, 0);
    @(negedge clk); valid_i = 1'b0;
    reqcyc = 0;
    while (dmemReq_o && reqcyc < 40) begin
      reqcyc++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(reqcyc), 32'd15);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_valid", 32'(valid_o), 32'd1);
    chk("to_stall", 32'(stall_o), 32'd0);
    @(negedge clk);

    // Reset asserted mid-WAIT
    issue(1,1,0,0,1,0,0,0, 32'h400, 5'd1, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); valid_i = 1'b0;
    chk("rw_wait_req", 32'(dmemReq_o), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("rstw_req", 32'(dmemReq_o), 32'd0);
    chk("rstw_stall", 32'(stall_o), 32'd0);
    chk("rstw_err", 32'(err_o), 32'd0);
    chk("rstw_valid", 32'(valid_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_req_after", 32'(dmemReq_o), 32'd0);

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n (asynchronous, active low).
REQ-002 Port list, one per line (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- valid_i  in  1  execute-stage output holds a live instruction
- wdSrc_i  in  1  1 = writeback immU, 0 = aluResult
- regWrite_i  in  1  instruction writes rd
- branch_i  in  1  conditional branch
- condZero_i  in  1  branch taken when aluZero equals this
- aluZero_i  in  1  ALU zero flag
- aluResult_i  in  32  ALU result; byte address for loads/stores
- rd_i  in  5  destination register
- immU_i  in  32  U-immediate
- pcBranch_i  in  32  branch target
- pcPlus4_i  in  32  fall-through PC (passed through)
- memRead_i  in  1  word load
- memWrite_i  in  1  word store
- storeData_i  in  32  store data
- dmemReq_o  out  1  data-memory request
- dmemWe_o  out  1  request is a write
- dmemAddr_o  out  32  word-aligned address
- dmemWdata_o  out  32  write data
- dmemAck_i  in  1  request done; rdata valid for loads
- dmemRdata_i  in  32  load data
- stall_o  out  1  upstream must hold its outputs
- pcSrc_o  out  1  taken branch, one cycle
- pcBranch_o  out  32  registered branch target
- pcPlus4_o  out  32  registered fall-through PC
- valid_o  out  1  one-cycle retire strobe
- regWrite_o  out  1  register-file write enable
- rd_o  out  5  writeback register
- wd3_o  out  32  writeback data
- err_o  out  1  sticky access error

Function
REQ-003 On each rising edge with stall_o=0, the block SHALL capture all *_i instruction fields into stage registers; with stall_o=1 it SHALL hold them.
REQ-004 FSM states SHALL be IDLE, WAIT, RESP.
REQ-005 IDLE: a captured valid non-memory instruction SHALL retire in the following cycle (valid_o=1): latency 1.
REQ-006 IDLE: a captured valid instruction with exactly one of memRead/memWrite and address bits [1:0]=00 SHALL go to WAIT.
REQ-007 WAIT SHALL drive dmemReq_o=1, dmemWe_o=memWrite, dmemAddr_o=aluResult, dmemWdata_o=storeData, and stall_o=1.
- Request fields SHALL stay stable until ack.
REQ-008 WAIT with dmemAck_i=1 SHALL latch dmemRdata_i, deassert dmemReq_o on the next edge, and go to RESP.
REQ-009 RESP SHALL assert valid_o for exactly one cycle with stall_o=0, then return to IDLE.
- The next instruction SHALL be captured on the edge that leaves RESP.
REQ-010 WAIT SHALL run a 4-bit cycle counter. If 15 cycles elapse without ack, the block SHALL:
- drop dmemReq_o;
- set err_o;
- go to RESP with regWrite_o suppressed.
REQ-011 A misaligned address (aluResult[1:0]!=00), or memRead=memWrite=1, SHALL:
- issue no request;
- set err_o;
- retire in 1 cycle with regWrite_o=0.
REQ-012 wd3_o SHALL be selected as follows: load data if memRead; else immU if wdSrc; else aluResult.
REQ-013 regWrite_o SHALL equal valid_o AND regWrite AND (rd!=0) AND no error on this instruction.
REQ-014 pcSrc_o SHALL equal valid_o AND branch AND (aluZero==condZero), for one cycle only.
REQ-015 valid_i=0 captured SHALL produce valid_o=0, regWrite_o=0, pcSrc_o=0, and no request.
REQ-016 err_o SHALL be sticky until reset.

Reset
REQ-017 rst_n=0 SHALL immediately force the following, regardless of state (including mid-WAIT):
- state=IDLE and counter=0;
- all outputs 0;
- all stage registers 0.

Verification
REQ-018 The bench SHALL cover:
- ALU op (aluResult=0x0000_0010, rd=5, regWrite=1) -> next cycle valid_o=1, regWrite_o=1, wd3_o=0x10, stall_o=0.
- Load at 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> stall_o high 3 cycles, then RESP with wd3_o=0xDEADBEEF, regWrite_o=1.
- Branch (branch=1, condZero=1, aluZero=1, pcBranch=0x40) -> pcSrc_o=1 for one cycle, pcBranch_o=0x40, regWrite_o=0.
- Store at 0x102 -> no dmemReq_o, err_o=1, valid_o one cycle, regWrite_o=0.
- Load never acked -> dmemReq_o drops after 15 cycles, err_o=1, regWrite_o=0.
- rst_n low during WAIT -> dmemReq_o and stall_o 0 immediately, err_o 0.
